branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped predictor entries (power of two, 4..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port PCF  input  32  fetch-stage PC to predict.
REQ-005 SHALL have port UpdateB  input  1  a resolved control-transfer instruction is in stage B this cycle.
REQ-006 SHALL have port PCB  input  32  PC of the resolved instruction.
REQ-007 SHALL have port TakenB  input  1  actual outcome of the resolved instruction (1 = taken).
REQ-008 SHALL have port TargetB  input  32  actual target of the resolved instruction.
REQ-009 SHALL have port Invalidate  input  1  single-cycle pulse requesting a full table clear (fence.i / context change).
REQ-010 SHALL have port BP  output  1  predict taken for PCF.
REQ-011 SHALL have port BPTarget  output  32  predicted target for PCF; the value is don't-care when BP=0.
REQ-012 SHALL have port BPBusy  output  1  a table clear is in progress.

Function
REQ-013 Index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2], IDX_W = log2(ENTRIES); PC[1:0] SHALL be ignored.
REQ-014 Each entry SHALL hold: valid bit, tag, 32-bit target, 2-bit saturating counter (SNT=0, WNT=1, WT=2, ST=3).
REQ-015 Lookup SHALL be combinational: BP=1 only when the entry is valid, the tag matches, counter is WT or ST, and state is READY; BPTarget = stored target.
REQ-016 Update SHALL be sequential: one cycle after UpdateB, the entry reflects the outcome; there is no same-cycle bypass, so a lookup of the same index in the update cycle returns pre-update contents.
REQ-017 Update on hit, TakenB=1: counter increments, saturating at ST; target is overwritten with TargetB.
REQ-018 Update on hit, TakenB=0: counter decrements, saturating at SNT; target is unchanged.
REQ-019 Update on miss (invalid entry or tag mismatch), TakenB=1: the entry is allocated with valid=1, new tag, target=TargetB, counter=WT, replacing any previous occupant.
REQ-020 Update on miss with TakenB=0: no table change (no allocation).
REQ-021 The FSM SHALL have states READY and CLEAR; reset enters READY with all valid bits 0.
REQ-022 READY to CLEAR on Invalidate=1; the clear index counter is set to 0.
REQ-023 In CLEAR, one entry's valid bit is cleared per cycle in ascending index order; the transition to READY occurs after index ENTRIES-1 is cleared (ENTRIES cycles total).
REQ-024 In CLEAR: BPBusy=1, BP=0, and UpdateB is ignored (update dropped).
REQ-025 Invalidate asserted during CLEAR SHALL restart the clear index at 0.
REQ-026 If Invalidate and UpdateB occur in the same READY cycle, Invalidate wins and the update is dropped.
REQ-027 A clear does not reset tags, targets, or counters; only valid bits are cleared.

Reset
REQ-028 Asserting reset (low) at any time, including mid-CLEAR, SHALL immediately force state READY, all valid bits 0, clear index 0, BP=0, and BPBusy=0.
REQ-029 Tags, targets, and counters SHALL need no reset value; outputs SHALL not depend on them while valid=0.

Structure
REQ-030 A shared package bp_pkg SHALL hold: the counter encoding typedef (SNT/WNT/WT/ST), the FSM state typedef (READY/CLEAR), and the default ENTRIES constant.
REQ-031 Counter next-state logic SHALL be a sub-module sat_counter2 (inputs: current counter and taken; output: next counter).

Verification
REQ-032 Cold miss: after reset, PCF=0x100 -> BP=0; update PCB=0x100, Taken=1, Target=0x200; next cycle PCF=0x100 -> BP=1, BPTarget=0x200.
REQ-033 Saturation: 3 taken updates at 0x100 -> counter=ST; 1 not-taken -> WT, BP=1; 2 more not-taken -> WNT then SNT, BP=0; further not-taken keeps SNT.
REQ-034 Aliasing (ENTRIES=16): allocate 0x100, then taken update at 0x140 (same index) -> lookup 0x100 gives BP=0, lookup 0x140 gives BP=1 with the new target.
REQ-035 Clear: populate 4 entries, pulse Invalidate -> BPBusy=1 for exactly 16 cycles, BP=0 throughout, updates during clear have no effect, and all lookups miss afterwards.
REQ-036 Reset mid-clear: assert reset at clear cycle 5 -> BPBusy=0 immediately; after release, state is READY and all entries miss.
REQ-037 Same-cycle: lookup and update of 0x100 in one cycle -> BP shows the old prediction; the following cycle shows the new one. Invalidate plus UpdateB together -> the update is dropped.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter encoding, control FSM states
// and the default table depth.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } bp_state_t;

  localparam int unsigned BP_ENTRIES_DEFAULT = 16;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t cnt_i,
  input  logic taken_i,
  output ctr_t cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != ST) cnt_o = ctr_t'(cnt_i + 2'd1);
    end else begin
      if (cnt_i != SNT) cnt_o = ctr_t'(cnt_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with 2-bit counters and stored targets;
// a table invalidate walks the valid bits one entry per cycle.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_ENTRIES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        UpdateB,
  input  logic [31:0] PCB,
  input  logic        TakenB,
  input  logic [31:0] TargetB,
  input  logic        Invalidate,
  output logic        BP,
  output logic [31:0] BPTarget,
  output logic        BPBusy
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  bp_state_t           state_q;
  logic [IDX_W-1:0]    clr_idx_q;
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];
  ctr_t                ctr_q [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_b;
  logic [TAG_W-1:0] tag_f, tag_b;
  logic             hit_b, upd_en;
  ctr_t             ctr_d;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_b = PCB[IDX_W+1:2];
  assign tag_b = PCB[31:IDX_W+2];

  assign BP = (state_q == READY) && valid_q[idx_f] && (tag_q[idx_f] == tag_f) &&
              ((ctr_q[idx_f] == WT) || (ctr_q[idx_f] == ST));
  assign BPTarget = tgt_q[idx_f];
  assign BPBusy   = (state_q == CLEAR);

  assign hit_b  = valid_q[idx_b] && (tag_q[idx_b] == tag_b);
  // Invalidate takes priority over a coincident update
  assign upd_en = (state_q == READY) && UpdateB && !Invalidate;

  sat_counter2 u_ctr (
    .cnt_i   (ctr_q[idx_b]),
    .taken_i (TakenB),
    .cnt_o   (ctr_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= READY;
      clr_idx_q <= '0;
      valid_q   <= '0;
    end else begin
      case (state_q)
        READY: begin
          if (Invalidate) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
          end else if (upd_en && !hit_b && TakenB) begin
            valid_q[idx_b] <= 1'b1;
          end
        end
        CLEAR: begin
          if (Invalidate) begin
            clr_idx_q <= '0;
          end else begin
            valid_q[clr_idx_q] <= 1'b0;
            if (clr_idx_q == IDX_W'(ENTRIES - 1)) state_q <= READY;
            else clr_idx_q <= clr_idx_q + IDX_W'(1);
          end
        end
        default: state_q <= READY;
      endcase
    end
  end

  // Payload fields are only meaningful behind a valid bit, so they carry no reset
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (hit_b) begin
        ctr_q[idx_b] <= ctr_d;
        if (TakenB) tgt_q[idx_b] <= TargetB;
      end else if (TakenB) begin
        tag_q[idx_b] <= tag_b;
        tgt_q[idx_b] <= TargetB;
        ctr_q[idx_b] <= WT;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic against a behavioural table model.
module tb_branch_predictor;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PCF = '0, PCB = '0, TargetB = '0;
  logic        UpdateB = 1'b0, TakenB = 1'b0, Invalidate = 1'b0;
  logic        BP, BPBusy;
  logic [31:0] BPTarget;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  bit          m_busy;
  int          m_clr;

  branch_predictor #(.ENTRIES(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .PCF        (PCF),
    .UpdateB    (UpdateB),
    .PCB        (PCB),
    .TakenB     (TakenB),
    .TargetB    (TargetB),
    .Invalidate (Invalidate),
    .BP         (BP),
    .BPTarget   (BPTarget),
    .BPBusy     (BPBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    int i = midx(pc);
    return !m_busy && m_valid[i] && (m_tag[i] == mtag(pc)) && (m_ctr[i] >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_busy = 1'b0;
    m_clr  = 0;
  endtask

  task automatic model_edge(input bit upd, input logic [31:0] pcb, input bit tk,
                            input logic [31:0] tgt, input bit inv);
    int i;
    if (m_busy) begin
      if (inv) m_clr = 0;
      else begin
        m_valid[m_clr] = 1'b0;
        if (m_clr == N - 1) m_busy = 1'b0;
        else m_clr++;
      end
    end else if (inv) begin
      m_busy = 1'b1;
      m_clr  = 0;
    end else if (upd) begin
      i = midx(pcb);
      if (m_valid[i] && m_tag[i] == mtag(pcb)) begin
        if (tk) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (tk) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = mtag(pcb);
        m_tgt[i]   = tgt;
        m_ctr[i]   = 2;
      end
    end
  endtask

  // One clock: drive, check lookup against model, then advance both at the edge
  task automatic tick(input bit upd, input logic [31:0] pcb, input bit tk,
                      input logic [31:0] tgt, input bit inv, input logic [31:0] pcf);
    bit eb;
    UpdateB = upd; PCB = pcb; TakenB = tk; TargetB = tgt; Invalidate = inv; PCF = pcf;
    #2;
    eb = m_pred(pcf);
    check("bp", {31'd0, BP}, {31'd0, eb});
    check("busy", {31'd0, BPBusy}, {31'd0, m_busy});
    if (eb) check("target", BPTarget, m_tgt[midx(pcf)]);
    @(posedge clk);
    model_edge(upd, pcb, tk, tgt, inv);
    #1;
    UpdateB = 1'b0; Invalidate = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    tick(1'b1, pc, tk, tgt, 1'b0, pc);
  endtask

  task automatic peek(input string tag, input logic [31:0] pc, input bit eb,
                      input logic [31:0] et);
    PCF = pc;
    #1;
    check(tag, {31'd0, BP}, {31'd0, eb});
    if (eb) check({tag, "_tgt"}, BPTarget, et);
  endtask

  initial begin
    int nb;
    logic [31:0] pc;
    model_reset();
    #1;
    check("rst_bp", {31'd0, BP}, 32'd0);
    check("rst_busy", {31'd0, BPBusy}, 32'd0);
    #12 reset = 1'b1;
    @(posedge clk); #1;

    // Cold miss then allocate
    peek("cold", 32'h100, 1'b0, '0);
    upd(32'h100, 1'b1, 32'h200);
    peek("alloc", 32'h100, 1'b1, 32'h200);
    peek("alloc_lowbits", 32'h103, 1'b1, 32'h200);

    // Saturation both ways
    upd(32'h100, 1'b1, 32'h204);
    upd(32'h100, 1'b1, 32'h208);
    peek("st", 32'h100, 1'b1, 32'h208);
    upd(32'h100, 1'b0, 32'h999);
    peek("st_to_wt", 32'h100, 1'b1, 32'h208);
    upd(32'h100, 1'b0, 32'h0);
    peek("wnt", 32'h100, 1'b0, '0);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h300);
    peek("snt_sat", 32'h100, 1'b0, '0);
    upd(32'h100, 1'b1, 32'h304);
    peek("snt_recover", 32'h100, 1'b1, 32'h304);

    // Aliasing on index 0
    upd(32'h140, 1'b1, 32'h500);
    peek("alias_old", 32'h100, 1'b0, '0);
    peek("alias_new", 32'h140, 1'b1, 32'h500);

    // Same-cycle lookup/update of one entry: pre-update contents visible
    tick(1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 32'h140);
    peek("after_same_cycle", 32'h140, 1'b0, '0);
    upd(32'h144, 1'b1, 32'h600);

    // Invalidate with a coincident update: update dropped
    tick(1'b1, 32'h148, 1'b1, 32'h700, 1'b1, 32'h144);

    // Clear: count busy cycles, updates ignored, all lookups miss after
    nb = 1;
    while (BPBusy && nb < 40) begin
      tick(1'b1, 32'h108 + 32'(4 * ($urandom % 4)), 1'b1, 32'hABC, 1'b0,
           32'h140 + 32'(4 * ($urandom % 4)));
      if (BPBusy) nb++;
    end
    check("clear_len", nb, N);
    peek("clr_miss0", 32'h144, 1'b0, '0);
    peek("clr_miss1", 32'h148, 1'b0, '0);
    peek("clr_miss2", 32'h108, 1'b0, '0);

    // Reset mid-clear
    upd(32'h10C, 1'b1, 32'h800);
    upd(32'h110, 1'b1, 32'h810);
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h10C);
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h110);
    #1 reset = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, BPBusy}, 32'd0);
    check("rstmid_bp", {31'd0, BP}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    peek("rstmid_miss", 32'h10C, 1'b0, '0);
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h110);

    // Random traffic over a small PC pool so hits, aliases and clears mix
    for (int c = 0; c < 800; c++) begin
      bit u, t, v;
      logic [31:0] pb, pf;
      u  = ($urandom % 3) != 0;
      t  = ($urandom % 3) != 0;
      v  = ($urandom % 60) == 0;
      pb = 32'(($urandom % 4) << 6) | 32'(($urandom % 8) << 2) | 32'($urandom % 4)
         | (($urandom % 2) != 0 ? 32'h8000_0000 : 32'h0);
      pf = (($urandom % 2) != 0) ? pb
         : 32'(($urandom % 4) << 6) | 32'(($urandom % 8) << 2);
      tick(u, pb, t, $urandom, v, pf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
